// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, response codes and bus widths.
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 16
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_pkg;

  localparam int APB_AW = `PADDR_WIDTH;
  localparam int APB_DW = `APB_DATA_WIDTH;

  // Slave-mux FSM states (2-bit encoding)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // APB pslverr encoding
  localparam logic APB_RESP_OKAY  = 1'b0;
  localparam logic APB_RESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_wdog_cnt.sv
// Saturating 8-bit access-phase wait counter with a TIMEOUT compare.
module apb_wdog_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  logic [7:0] r_cnt;

  // Count wait cycles; clear wins over increment, saturate at 255
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_inc && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expired = (r_cnt >= 8'(TIMEOUT));

endmodule

// File: rtl/apb_slave_mux.sv
// APB fan-out: address decode to one-hot slave selects, response mux back
// to the bridge, error response for unmapped windows and a wait watchdog.
module apb_slave_mux
  import apb_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW,
  parameter int IDX_LSB = 12,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic                  psel_en,
  input  logic                  penable,
  input  logic [AW-1:0]         paddr,
  output logic [NUM_SLV-1:0]    psel_s,
  input  logic [NUM_SLV*DW-1:0] prdata_s,
  input  logic [NUM_SLV-1:0]    pready_s,
  input  logic [NUM_SLV-1:0]    pslverr_s,
  output logic [DW-1:0]         prdata_x,
  output logic                  pready_x,
  output logic                  pslverr_x,
  output logic                  to_flag,
  input  logic                  to_clr
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_mapped;
  logic             r_to_flag;

  logic [IDX_W-1:0] w_idx;
  logic             w_mapped;
  logic             w_latch;
  logic             w_inc;
  logic             w_force;
  logic             w_expired;
  logic             w_resp;
  logic             w_err;
  logic [DW-1:0]    w_data;
  logic             w_slv_rdy;
  logic             w_slv_err;
  logic [DW-1:0]    w_slv_data;
  logic             w_unused_addr;

  // Only the index field of paddr takes part in decode
  assign w_unused_addr = ^paddr;
  assign w_idx    = paddr[IDX_LSB +: IDX_W];
  assign w_mapped = (int'(w_idx) < NUM_SLV);

  // Live decode so a select drops in the same cycle as psel_en; forced low in reset
  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_sel
    assign psel_s[gi] = hreset_n & psel_en & w_mapped & (int'(w_idx) == gi);
  end

  // Select the response of the slave latched at setup, never the live address
  always_comb begin
    w_slv_rdy  = 1'b0;
    w_slv_err  = 1'b0;
    w_slv_data = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (int'(r_idx) == i) begin
        w_slv_rdy  = pready_s[i];
        w_slv_err  = pslverr_s[i];
        w_slv_data = prdata_s[i*DW +: DW];
      end
    end
  end

  // Next state and response. The setup cycle is only recognised once it has
  // been seen, so ST_SETUP is the registered state during the first access
  // cycle; the response logic therefore runs in both ST_SETUP and ST_ACCESS.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_inc       = 1'b0;
    w_force     = 1'b0;
    w_resp      = 1'b0;
    w_err       = APB_RESP_OKAY;
    w_data      = '0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (psel_en && !penable) begin
          w_state_nxt = ST_SETUP;
          w_latch     = 1'b1;
        end else if (!psel_en) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP, ST_ACCESS: begin
        if (!psel_en) begin
          w_state_nxt = ST_IDLE;
        end else if (!penable) begin
          if (r_state == ST_SETUP) begin
            w_latch = 1'b1;
          end
        end else if (!r_mapped) begin
          w_resp      = 1'b1;
          w_err       = APB_RESP_ERROR;
          w_state_nxt = ST_DONE;
        end else if (w_slv_rdy) begin
          w_resp      = 1'b1;
          w_err       = w_slv_err;
          w_data      = w_slv_data;
          w_state_nxt = ST_DONE;
        end else if (w_expired) begin
          w_resp      = 1'b1;
          w_err       = APB_RESP_ERROR;
          w_force     = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_inc       = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign pready_x  = w_resp;
  assign pslverr_x = w_resp & w_err;
  assign prdata_x  = w_data;
  assign to_flag   = r_to_flag;

  // FSM state and the slave index / mapped bit captured at setup
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_mapped <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_idx    <= w_idx;
        r_mapped <= w_mapped;
      end
    end
  end

  // Sticky watchdog flag; a timeout in the same cycle beats to_clr
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_to_flag <= 1'b0;
    end else if (w_force) begin
      r_to_flag <= 1'b1;
    end else if (to_clr) begin
      r_to_flag <= 1'b0;
    end
  end

  apb_wdog_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clk     (hclk),
    .i_rst_n   (hreset_n),
    .i_clr     (w_latch),
    .i_inc     (w_inc),
    .o_expired (w_expired)
  );

endmodule

// File: tb/tb_apb_slave_mux.sv
// Scoreboard bench for apb_slave_mux: expected responses are queued as each
// transfer is issued and popped whenever the DUT raises pready_x.
module tb_apb_slave_mux;

  localparam int NUM_SLV = 4;
  localparam int AW      = 16;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  typedef logic [DW:0] sb_t;  // {data, slverr}

  logic                  hclk;
  logic                  hreset_n;
  logic                  psel_en;
  logic                  penable;
  logic [AW-1:0]         paddr;
  logic [NUM_SLV-1:0]    psel_s;
  logic [NUM_SLV*DW-1:0] prdata_s;
  logic [NUM_SLV-1:0]    pready_s;
  logic [NUM_SLV-1:0]    pslverr_s;
  logic [DW-1:0]         prdata_x;
  logic                  pready_x;
  logic                  pslverr_x;
  logic                  to_flag;
  logic                  to_clr;

  int  n_tests = 0;
  int  n_fail  = 0;
  sb_t sb_q[$];
  sb_t mon_e;

  apb_slave_mux #(
    .NUM_SLV (NUM_SLV),
    .AW      (AW),
    .DW      (DW),
    .IDX_LSB (12),
    .IDX_W   (3),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .psel_en   (psel_en),
    .penable   (penable),
    .paddr     (paddr),
    .psel_s    (psel_s),
    .prdata_s  (prdata_s),
    .pready_s  (pready_s),
    .pslverr_s (pslverr_s),
    .prdata_x  (prdata_x),
    .pready_x  (pready_x),
    .pslverr_x (pslverr_x),
    .to_flag   (to_flag),
    .to_clr    (to_clr)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every pready_x pulse must match the oldest outstanding expectation
  always @(negedge hclk) begin
    if (pready_x === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_extra_pulse", 64'(pready_x), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_rdata", 64'(prdata_x), 64'(mon_e[DW:1]));
        chk("sb_slverr", 64'(pslverr_x), 64'(mon_e[0]));
      end
    end
  end

  // One APB transfer. slv<0: unmapped; wait_n<0: slave never ready.
  task automatic xfer(input logic [AW-1:0] addr, input int slv, input int wait_n,
                      input logic [DW-1:0] data, input logic err,
                      input logic [NUM_SLV-1:0] exp_psel, input logic exp_flag);
    int          exp_cyc;
    logic [DW-1:0] e_data;
    logic        e_err;
    int          k;
    bit          done;
    if (slv < 0) begin
      exp_cyc = 1; e_data = '0; e_err = 1'b1;
    end else if (wait_n < 0 || wait_n > TIMEOUT) begin
      exp_cyc = TIMEOUT + 1; e_data = '0; e_err = 1'b1;
    end else begin
      exp_cyc = wait_n + 1; e_data = data; e_err = err;
    end
    if (slv >= 0) begin
      prdata_s[slv*DW +: DW] = data;
      pslverr_s[slv]         = err;
      pready_s[slv]          = 1'b0;
    end
    sb_q.push_back({e_data, e_err});
    @(posedge hclk); #1;
    psel_en = 1'b1; penable = 1'b0; paddr = addr;
    @(negedge hclk);
    chk("psel_setup", 64'(psel_s), 64'(exp_psel));
    chk("rdy_setup", 64'(pready_x), 64'd0);
    done = 1'b0;
    k    = 0;
    while (!done && k < 40) begin
      @(posedge hclk); #1;
      penable = 1'b1;
      if (slv >= 0) pready_s[slv] = (wait_n >= 0 && k >= wait_n);
      k++;
      @(negedge hclk);
      chk("psel_acc", 64'(psel_s), 64'(exp_psel));
      if (pready_x === 1'b1) done = 1'b1;
    end
    chk("acc_cycles", 64'(k), 64'(exp_cyc));
    // bus held one more cycle: no second pulse, outputs back to 0
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("rdy_done", 64'(pready_x), 64'd0);
    chk("err_done", 64'(pslverr_x), 64'd0);
    chk("data_done", 64'(prdata_x), 64'd0);
    chk("to_flag", 64'(to_flag), 64'(exp_flag));
    @(posedge hclk); #1;
    psel_en = 1'b0; penable = 1'b0;
    if (slv >= 0) pready_s[slv] = 1'b0;
    @(negedge hclk);
    chk("psel_idle", 64'(psel_s), 64'd0);
    chk("rdy_idle", 64'(pready_x), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    hreset_n  = 1'b0;
    psel_en   = 1'b1;
    penable   = 1'b0;
    paddr     = 16'h1000;
    prdata_s  = {32'hC0C0_0003, 32'hC0C0_0002, 32'hC0C0_0001, 32'hC0C0_0000};
    pready_s  = '0;
    pslverr_s = '0;
    to_clr    = 1'b0;

    // reset state with the bus already selecting slave 1
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("rst_psel", 64'(psel_s), 64'd0);
    chk("rst_rdy", 64'(pready_x), 64'd0);
    chk("rst_err", 64'(pslverr_x), 64'd0);
    chk("rst_data", 64'(prdata_x), 64'd0);
    chk("rst_flag", 64'(to_flag), 64'd0);
    psel_en = 1'b0;
    @(posedge hclk); #1;
    hreset_n = 1'b1;

    // read slave 1, ready at once
    xfer(16'h1004, 1, 0, 32'hDEAD_BEEF, 1'b0, 4'b0010, 1'b0);
    // slave 3, 5 wait cycles then error
    xfer(16'h3000, 3, 5, 32'h3333_3333, 1'b1, 4'b1000, 1'b0);
    // unmapped windows: idx 5 and the first one past the last slave
    pready_s = '1;
    xfer(16'h5000, -1, 0, 32'h0, 1'b0, 4'b0000, 1'b0);
    xfer(16'h4ABC, -1, 0, 32'h0, 1'b0, 4'b0000, 1'b0);
    pready_s = '0;

    // enable without setup: ignored, no response
    pready_s[0] = 1'b1;
    @(posedge hclk); #1;
    psel_en = 1'b1; penable = 1'b1; paddr = 16'h0000;
    repeat (2) begin
      @(negedge hclk);
      chk("noset_psel", 64'(psel_s), 64'd1);
      chk("noset_rdy", 64'(pready_x), 64'd0);
      @(posedge hclk); #1;
    end
    psel_en = 1'b0; penable = 1'b0; pready_s[0] = 1'b0;

    // ready arrives exactly in the expiry cycle: slave response wins
    xfer(16'h2010, 2, TIMEOUT, 32'h2222_0016, 1'b0, 4'b0100, 1'b0);
    // slave 0 never ready: forced error in access cycle TIMEOUT+1
    xfer(16'h0040, 0, -1, 32'h0BAD_0BAD, 1'b0, 4'b0001, 1'b1);
    @(posedge hclk); #1; to_clr = 1'b1;
    @(posedge hclk); #1; to_clr = 1'b0;
    @(negedge hclk);
    chk("flag_clr", 64'(to_flag), 64'd0);

    // back-to-back: slave 2 then slave 0, slave 2 keeps ready/error high
    pslverr_s[2] = 1'b1;
    xfer(16'h2000, 2, 0, 32'hAAAA_2222, 1'b1, 4'b0100, 1'b0);
    pready_s[2] = 1'b1;
    xfer(16'h0008, 0, 2, 32'hBBBB_0000, 1'b0, 4'b0001, 1'b0);
    pready_s[2] = 1'b0;

    // set the flag again, then reset mid-transfer must clear everything
    xfer(16'h0000, 0, -1, 32'h0, 1'b0, 4'b0001, 1'b1);
    pready_s[1] = 1'b0;
    @(posedge hclk); #1;
    psel_en = 1'b1; penable = 1'b0; paddr = 16'h1000;
    repeat (3) begin
      @(posedge hclk); #1;
      penable = 1'b1;
    end
    #2;
    hreset_n    = 1'b0;
    pready_s[1] = 1'b1;
    #1;
    chk("arst_psel", 64'(psel_s), 64'd0);
    chk("arst_rdy", 64'(pready_x), 64'd0);
    chk("arst_err", 64'(pslverr_x), 64'd0);
    chk("arst_data", 64'(prdata_x), 64'd0);
    chk("arst_flag", 64'(to_flag), 64'd0);
    @(posedge hclk); #1;
    psel_en = 1'b0; penable = 1'b0; pready_s[1] = 1'b0;
    @(posedge hclk); #1;
    hreset_n = 1'b1;
    xfer(16'h1ABC, 1, 0, 32'h1234_5678, 1'b0, 4'b0010, 1'b0);

    // timeout with to_clr held: the set wins, then the clear takes effect
    to_clr = 1'b1;
    xfer(16'h3000, 3, -1, 32'h0, 1'b0, 4'b1000, 1'b1);
    @(negedge hclk);
    chk("flag_held_clr", 64'(to_flag), 64'd0);
    to_clr = 1'b0;

    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
